lsu: RTL and testbench

- Multi-cycle load/store unit between EXU (address = alu_out, store data = rf_rdata2) and the data memory bus.
- Accepts one access per request. Issues an aligned bus request with byte mask, waits for the memory response, then extracts and extends load data.
- Returns the result to the register-file write-back mux (the rf_wr_sel path).
- Core stalls via lsu_ready/lsu_resp_valid.

---
 rtl/lsu.sv | 166 ++++++++++++++++
 tb/tb_lsu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Multi-cycle load/store unit: one access per request, lane-aligned bus transfer with byte mask,
// then load extraction and sign/zero extension. Optional misalignment trap: LSU_MISALIGN_CHECK_EN.
module lsu #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ALIGN_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              lsu_wen,
    input  logic [2:0]        lsu_op,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic [XLEN-1:0]   lsu_wdata,
    output logic              lsu_resp_valid,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              lsu_err,
    output logic              dmem_valid,
    input  logic              dmem_ready,
    output logic [XLEN-1:0]   dmem_addr,
    output logic              dmem_wen,
    output logic [XLEN/8-1:0] dmem_wmask,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);
    localparam int unsigned Lanes = XLEN / 8;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    addr_q, wdata_q, rdata_q, rdata_d;
    logic [2:0]         op_q;
    logic               wen_q;
    logic               accept, misaligned, rdata_en, in_req;
    logic [ALIGN_W-1:0] off_q;
    logic [3:0]         nbytes;
    logic [Lanes-1:0]   wmask;
    logic [XLEN-1:0]    shifted, load_ext;

    assign off_q  = addr_q[ALIGN_W-1:0];
    assign nbytes = 4'd1 << op_q[1:0];
    assign in_req = (state_q == StReq);

`ifdef LSU_MISALIGN_CHECK_EN
    logic               err_q;
    logic [ALIGN_W-1:0] size_m1;

    assign size_m1    = ALIGN_W'((32'd1 << lsu_op[1:0]) - 32'd1);
    assign misaligned = |(lsu_addr[ALIGN_W-1:0] & size_m1);
    assign lsu_err    = (state_q == StDone) && err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign lsu_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        rdata_en       = 1'b0;
        rdata_d        = '0;
        lsu_ready      = 1'b0;
        lsu_resp_valid = 1'b0;
        dmem_valid     = 1'b0;
        unique case (state_q)
            StIdle: begin
                lsu_ready = 1'b1;
                if (lsu_valid) begin
                    accept = 1'b1;
                    if (misaligned) begin
                        // Trapped access: result reads 0, bus untouched.
                        state_d  = StDone;
                        rdata_en = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                dmem_valid = 1'b1;
                if (dmem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dmem_rvalid) begin
                    state_d  = StDone;
                    rdata_en = 1'b1;
                    rdata_d  = wen_q ? '0 : load_ext;
                end
            end
            StDone: begin
                lsu_resp_valid = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= lsu_addr;
                wdata_q <= lsu_wdata;
                op_q    <= lsu_op;
                wen_q   <= lsu_wen;
            end
            if (rdata_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    // Lanes past the top of the bus word are simply never enabled.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < int'(Lanes); i++) begin
            wmask[i] = (i >= int'(off_q)) && (i < int'(off_q) + int'(nbytes));
        end
    end

    assign shifted = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = shifted;
        unique case (op_q[1:0])
            2'b00: load_ext = op_q[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                      : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = op_q[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                      : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            2'b10: load_ext = op_q[2] ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                      : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            2'b11: load_ext = shifted;
            default: load_ext = shifted;
        endcase
    end

    assign dmem_addr  = in_req ? {addr_q[XLEN-1:ALIGN_W], {ALIGN_W{1'b0}}} : '0;
    assign dmem_wen   = in_req && wen_q;
    assign dmem_wmask = in_req ? wmask : '0;
    assign dmem_wdata = in_req ? (wdata_q << {off_q, 3'b000}) : '0;
    assign lsu_rdata  = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table over a scripted bus, plus stall, misalignment and
// mid-operation reset sequences.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic        lsu_wen = 1'b0;
    logic [2:0]  lsu_op = 3'd0;
    logic [63:0] lsu_addr = '0;
    logic [63:0] lsu_wdata = '0;
    logic        lsu_resp_valid;
    logic [63:0] lsu_rdata;
    logic        lsu_err;
    logic        dmem_valid;
    logic        dmem_ready = 1'b0;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [7:0]  dmem_wmask;
    logic [63:0] dmem_wdata;
    logic        dmem_rvalid = 1'b0;
    logic [63:0] dmem_rdata = '0;

    int checks = 0;
    int errors = 0;

    lsu #(.XLEN(64), .ALIGN_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_wen        (lsu_wen),
        .lsu_op         (lsu_op),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_err        (lsu_err),
        .dmem_valid     (dmem_valid),
        .dmem_ready     (dmem_ready),
        .dmem_addr      (dmem_addr),
        .dmem_wen       (dmem_wen),
        .dmem_wmask     (dmem_wmask),
        .dmem_wdata     (dmem_wdata),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata_in;
        logic [63:0] exp_addr;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic wen, input logic [2:0] op, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] rin,
                                input logic [63:0] eaddr, input logic [7:0] emask,
                                input logic [63:0] ewdata, input logic [63:0] erdata);
        vec_t v;
        v.wen = wen; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata_in = rin;
        v.exp_addr = eaddr; v.exp_mask = emask; v.exp_wdata = ewdata; v.exp_rdata = erdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One access; rdly = cycles dmem_ready held low, vdly = cycles before dmem_rvalid.
    task automatic run(input string nm, input vec_t v, input int rdly, input int vdly,
                       input bit misal);
        @(negedge clk);
        chk({nm, " ready_idle"}, 64'(lsu_ready), 64'd1);
        lsu_valid  = 1'b1;
        lsu_wen    = v.wen;
        lsu_op     = v.op;
        lsu_addr   = v.addr;
        lsu_wdata  = v.wdata;
        dmem_rdata = v.rdata_in;
        dmem_ready = 1'b0;
        @(negedge clk);
        if (misal) begin
            lsu_valid = 1'b0;
            chk({nm, " no_bus"}, 64'(dmem_valid), 64'd0);
            chk({nm, " resp_t1"}, 64'(lsu_resp_valid), 64'd1);
            chk({nm, " err"}, 64'(lsu_err), 64'd1);
            chk({nm, " rdata"}, lsu_rdata, 64'd0);
        end else begin
            for (int k = 0; k <= rdly; k++) begin
                // Requests arriving while busy must be ignored.
                lsu_valid = 1'b1;
                lsu_addr  = ~v.addr;
                chk({nm, " dmem_valid"}, 64'(dmem_valid), 64'd1);
                chk({nm, " ready_busy"}, 64'(lsu_ready), 64'd0);
                chk({nm, " dmem_addr"}, dmem_addr, v.exp_addr);
                chk({nm, " dmem_wen"}, 64'(dmem_wen), 64'(v.wen));
                chk({nm, " wmask"}, 64'(dmem_wmask), 64'(v.exp_mask));
                chk({nm, " dmem_wdata"}, dmem_wdata, v.exp_wdata);
                dmem_ready = (k == rdly);
                @(negedge clk);
            end
            lsu_valid  = 1'b0;
            dmem_ready = 1'b0;
            for (int j = 0; j <= vdly; j++) begin
                chk({nm, " wait_no_valid"}, 64'(dmem_valid), 64'd0);
                chk({nm, " wait_no_resp"}, 64'(lsu_resp_valid), 64'd0);
                dmem_rvalid = (j == vdly);
                @(negedge clk);
            end
            dmem_rvalid = 1'b0;
            dmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
            chk({nm, " resp"}, 64'(lsu_resp_valid), 64'd1);
            chk({nm, " rdata"}, lsu_rdata, v.exp_rdata);
            chk({nm, " err"}, 64'(lsu_err), 64'd0);
        end
        @(negedge clk);
        chk({nm, " resp_once"}, 64'(lsu_resp_valid), 64'd0);
        chk({nm, " ready_back"}, 64'(lsu_ready), 64'd1);
        chk({nm, " rdata_hold"}, lsu_rdata, misal ? 64'd0 : v.exp_rdata);
    endtask

    vec_t vecs[11];
    vec_t v_lw, v_mis, v_sd;
    bit   mis_en;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1, 3'b000, 64'h8000_0003, 64'h12AB, 64'h0, 64'h8000_0000, 8'h08,
                      64'h0000_0012_AB00_0000, 64'h0);
        vecs[1]  = mk(0, 3'b000, 64'h8000_0005, 64'h0, 64'h0000_8000_0000_0000, 64'h8000_0000,
                      8'h20, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        vecs[2]  = mk(0, 3'b100, 64'h8000_0005, 64'h0, 64'h0000_8000_0000_0000, 64'h8000_0000,
                      8'h20, 64'h0, 64'h0000_0000_0000_0080);
        vecs[3]  = mk(1, 3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 64'h8000_0008,
                      8'hFF, 64'h1122_3344_5566_7788, 64'h0);
        vecs[4]  = mk(0, 3'b011, 64'h8000_0010, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 64'h8000_0010,
                      8'hFF, 64'h0, 64'hDEAD_BEEF_CAFE_F00D);
        vecs[5]  = mk(0, 3'b101, 64'h8000_0006, 64'h0, 64'hABCD_0000_0000_0000, 64'h8000_0000,
                      8'hC0, 64'h0, 64'h0000_0000_0000_ABCD);
        vecs[6]  = mk(0, 3'b001, 64'h8000_0006, 64'h0, 64'hABCD_0000_0000_0000, 64'h8000_0000,
                      8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD);
        vecs[7]  = mk(0, 3'b110, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 64'h8000_0000,
                      8'hF0, 64'h0, 64'h0000_0000_8765_4321);
        vecs[8]  = mk(1, 3'b001, 64'h8000_0002, 64'hFFFF_BEEF, 64'h0, 64'h8000_0000, 8'h0C,
                      64'h0000_FFFF_BEEF_0000, 64'h0);
        vecs[9]  = mk(1, 3'b010, 64'h8000_0004, 64'h1234_5678, 64'h0, 64'h8000_0000, 8'hF0,
                      64'h1234_5678_0000_0000, 64'h0);
        vecs[10] = mk(0, 3'b111, 64'h8000_0018, 64'h0, 64'h8000_0000_0000_0001, 64'h8000_0018,
                      8'hFF, 64'h0, 64'h8000_0000_0000_0001);
        v_lw  = mk(0, 3'b010, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 64'h8000_0000,
                   8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321);
        v_mis = mk(0, 3'b001, 64'h8000_0001, 64'h0, 64'h0000_0000_00AB_CD00, 64'h8000_0000,
                   8'h06, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD);
        v_sd  = mk(1, 3'b011, 64'h8000_0008, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 64'h8000_0008,
                   8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        mis_en = 1'b1;
`else
        mis_en = 1'b0;
`endif

        // Reset state.
        #2;
        chk("rst ready", 64'(lsu_ready), 64'd1);
        chk("rst dmem_valid", 64'(dmem_valid), 64'd0);
        chk("rst resp", 64'(lsu_resp_valid), 64'd0);
        chk("rst rdata", lsu_rdata, 64'd0);
        chk("rst err", 64'(lsu_err), 64'd0);
        chk("rst wmask", 64'(dmem_wmask), 64'd0);
        chk("rst dmem_addr", dmem_addr, 64'd0);
        #20 rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run($sformatf("vec%0d", i), vecs[i], 0, 0, 1'b0);
        end

        run("lw_stall", v_lw, 3, 2, 1'b0);
        run("lh_misalign", v_mis, 0, 0, mis_en);

        // Reset while waiting for the response.
        @(negedge clk);
        lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_op = 3'b011; lsu_addr = 64'h8000_0020;
        dmem_rdata = 64'h5555_6666_7777_8888;
        @(negedge clk);
        lsu_valid  = 1'b0;
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("mid wait_busy", 64'(lsu_ready), 64'd0);
        #1 rst = 1'b0;
        #1;
        chk("mid dmem_valid", 64'(dmem_valid), 64'd0);
        chk("mid resp", 64'(lsu_resp_valid), 64'd0);
        chk("mid ready", 64'(lsu_ready), 64'd1);
        chk("mid rdata_cleared", lsu_rdata, 64'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("stale resp", 64'(lsu_resp_valid), 64'd0);
        chk("stale ready", 64'(lsu_ready), 64'd1);
        @(negedge clk);
        chk("stale resp2", 64'(lsu_resp_valid), 64'd0);
        chk("stale rdata", lsu_rdata, 64'd0);
        run("sd_after_rst", v_sd, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
